// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit: one shift-add or shift-subtract per cycle.
// Build option MULDIV_DIV_EN enables the divide datapath; without it divide ops are flagged illegal.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on the accepting edge
// PREP   | absolute values and result signs
// RUN    | 32 iterations, one per cycle
// FIX    | sign correction; results written on the exit edge
// DONE   | one-cycle done pulse
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:1]  op,
    input  logic [0:31] opA,
    input  logic [0:31] opB,
    output logic        busy,
    output logic        done,
    output logic [0:31] hi,
    output logic [0:31] lo,
    output logic        dbz,
    output logic        illegal
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        signed_q, signed_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] prod_q, prod_d;
    logic        neg_res_q, neg_res_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;
    logic        ill_q, ill_d;

    logic [1:0]  op_in;
    logic [31:0] a_in, b_in;
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [63:0] prod_fix;

    assign op_in = op;
    assign a_in  = opA;
    assign b_in  = opB;

    assign a_neg = signed_q & a_q[31];
    assign b_neg = signed_q & b_q[31];
    assign a_abs = a_neg ? -a_q : a_q;
    assign b_abs = b_neg ? -b_q : b_q;

    // Multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
    assign prod_fix = neg_res_q ? -prod_q : prod_q;

`ifdef MULDIV_DIV_EN
    logic        div_q, div_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_rem_q, neg_rem_d;
    logic        zero_q, zero_d;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] rem_sub;
    logic [31:0] rem_nxt;

    // Partial remainder is 33 bits wide; after a restoring step it always fits in 32.
    assign rem_sh  = {rem_q, prod_q[31]};
    assign div_ge  = rem_sh >= {1'b0, b_q};
    assign rem_sub = rem_sh[31:0] - b_q;
    assign rem_nxt = div_ge ? rem_sub : rem_sh[31:0];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        signed_d  = signed_q;
        a_d       = a_q;
        b_d       = b_q;
        prod_d    = prod_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        ill_d     = ill_q;
`ifdef MULDIV_DIV_EN
        div_d     = div_q;
        rem_d     = rem_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_PREP;
                    signed_d = op_in[0];
                    a_d      = a_in;
                    b_d      = b_in;
`ifdef MULDIV_DIV_EN
                    div_d    = op_in[1];
`else
                    if (op_in[1]) begin
                        state_d = S_DONE;
                        hi_d    = '0;
                        lo_d    = '0;
                        dbz_d   = 1'b0;
                        ill_d   = 1'b1;
                    end
`endif
                end
            end
            S_PREP: begin
                state_d   = S_RUN;
                cnt_d     = '0;
                a_d       = a_abs;
                b_d       = b_abs;
                neg_res_d = a_neg ^ b_neg;
                prod_d    = {32'd0, b_abs};
`ifdef MULDIV_DIV_EN
                neg_rem_d = a_neg;
                zero_d    = (b_q == 32'd0);
                rem_d     = '0;
                if (div_q) prod_d = {32'd0, a_abs};
`endif
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    prod_d = {prod_q[63:32], prod_q[30:0], div_ge};
                    rem_d  = rem_nxt;
                end else
`endif
                prod_d = {mul_sum, prod_q[31:1]};
            end
            S_FIX: begin
                state_d = S_DONE;
                hi_d    = prod_fix[63:32];
                lo_d    = prod_fix[31:0];
                dbz_d   = 1'b0;
                ill_d   = 1'b0;
`ifdef MULDIV_DIV_EN
                // Remainder follows the dividend; divide-by-zero forces an all-ones quotient.
                if (div_q) begin
                    hi_d  = neg_rem_q ? -rem_q : rem_q;
                    lo_d  = zero_q ? 32'hFFFF_FFFF : (neg_res_q ? -prod_q[31:0] : prod_q[31:0]);
                    dbz_d = zero_q;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
            ill_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q     <= 1'b0;
            rem_q     <= '0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            signed_q  <= signed_d;
            a_q       <= a_d;
            b_q       <= b_d;
            prod_q    <= prod_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
            ill_q     <= ill_d;
`ifdef MULDIV_DIV_EN
            div_q     <= div_d;
            rem_q     <= rem_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign dbz     = dbz_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected results, a monitor checks each done pulse.
// Divide expectations follow MULDIV_DIV_EN (real results when defined, illegal flag otherwise).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA, opB;
    logic        busy, done, dbz, illegal;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .opA     (opA),
        .opB     (opB),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dbz     (dbz),
        .illegal (illegal)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        ill;
        int          done_edge;
        int          busy_cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        ill;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   busy_cyc = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!busy) busy_cyc = 0;
        else       busy_cyc = busy_cyc + 1;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done_high required=no_done (edge %0d)", edge_cnt);
            end else begin
                e = sb.pop_front();
                chk("result_hi_lo", {hi, lo}, {e.hi, e.lo});
                chk("flags_dbz_illegal", {62'd0, dbz, illegal}, {62'd0, e.dbz, e.ill});
                chk("done_edge", 64'(edge_cnt), 64'(e.done_edge));
                chk("busy_cycles", 64'(busy_cyc), 64'(e.busy_cyc));
            end
        end
    end

    task automatic add_vec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] h, input logic [31:0] l, input logic z);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l; v.dbz = z; v.ill = 1'b0; v.lat = 35;
`ifndef MULDIV_DIV_EN
        if (o[1]) begin
            v.hi = '0; v.lo = '0; v.dbz = 1'b0; v.ill = 1'b1; v.lat = 1;
        end
`endif
        vecs.push_back(v);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done");
        end
    endtask

    // Returns just after the accepting edge so callers can disturb the operation in flight.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l, input logic z,
                         input logic il, input int lat);
        exp_t e;
        wait_idle();
        op = o; opA = a; opB = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.hi = h; e.lo = l; e.dbz = z; e.ill = il;
        e.done_edge = edge_cnt + lat - 1;
        e.busy_cyc  = lat;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; start = 1'b0; op = '0; opA = '0; opB = '0;
        #12;
        chk("reset_ctrl", {60'd0, busy, done, dbz, illegal}, 64'd0);
        chk("reset_data", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        add_vec(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        add_vec(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        add_vec(2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        add_vec(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        add_vec(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        add_vec(2'b00, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 1'b0);
        add_vec(2'b01, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        add_vec(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        add_vec(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        add_vec(2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        add_vec(2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        add_vec(2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);
        add_vec(2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        add_vec(2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        add_vec(2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                  vecs[i].dbz, vecs[i].ill, vecs[i].lat);
            wait_done();
        end

        // Start held only through the DONE cycle must not launch anything.
        issue(2'b00, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 1'b0, 35);
        wait_done();
        op = 2'b00; opA = 32'd3; opB = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_in_done_ignored", {63'd0, busy}, 64'd0);

        // Operand change at edge 5 and a second start at edge 10 leave the result alone.
        issue(2'b00, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, 1'b0, 35);
        repeat (3) @(posedge clk);
        #1;
        opA = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; opA = 32'd7; opB = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("no_queued_start", {63'd0, busy}, 64'd0);

        // Abort at edge 20, then restart on the first edge after release.
`ifdef MULDIV_DIV_EN
        issue(2'b10, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 1'b0, 35);
`else
        issue(2'b00, 32'd1000, 32'd7, 32'd0, 32'd7000, 1'b0, 1'b0, 35);
`endif
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_ctrl", {62'd0, busy, done}, 64'd0);
        chk("abort_data", {hi, lo}, 64'd0);
        sb.delete();
        op = 2'b00; opA = 32'd6; opB = 32'd7; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            exp_t e;
            e.hi = 32'd0; e.lo = 32'd42; e.dbz = 1'b0; e.ill = 1'b0;
            e.done_edge = edge_cnt + 34;
            e.busy_cyc  = 35;
            sb.push_back(e);
        end
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
